// File: rtl/pc_next_reg_pkg.sv
// Shared encodings for the next-PC path: pc_src selector values, sequencer
// states and the fetch increment, so PC control and this block agree.
package pc_next_reg_pkg;

    localparam logic [2:0] PCS_HOLD  = 3'b000;
    localparam logic [2:0] PCS_SEQ   = 3'b001;
    localparam logic [2:0] PCS_JREG  = 3'b010;
    localparam logic [2:0] PCS_BR    = 3'b011;
    localparam logic [2:0] PCS_JDISP = 3'b100;

    localparam int PC_INC = 2;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_ERR  = 2'd2
    } pc_state_t;

endpackage

// File: rtl/pc_next_reg_target_mux.sv
// Combinational next-PC candidate selection with legality and alignment
// checks; all adds wrap modulo 2^WIDTH.
module pc_target_mux
    import pc_next_reg_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] pc,
    input  logic [2:0]       pc_src,
    input  logic [WIDTH-1:0] br_off,
    input  logic [WIDTH-1:0] jmp_off,
    input  logic [WIDTH-1:0] reg_tgt,
    output logic [WIDTH-1:0] pc_plus2,
    output logic [WIDTH-1:0] cand,
    output logic             illegal,
    output logic             misaligned,
    output logic             nonseq
);

    assign pc_plus2 = pc + WIDTH'(PC_INC);

    always_comb begin
        cand    = pc;
        illegal = 1'b0;
        nonseq  = 1'b0;
        case (pc_src)
            PCS_HOLD:  cand = pc;
            PCS_SEQ:   cand = pc_plus2;
            PCS_BR: begin
                cand   = pc_plus2 + br_off;
                nonseq = 1'b1;
            end
            PCS_JDISP: begin
                cand   = pc_plus2 + jmp_off;
                nonseq = 1'b1;
            end
            PCS_JREG: begin
                cand   = reg_tgt;
                nonseq = 1'b1;
            end
            default:   illegal = 1'b1;
        endcase
    end

    // An illegal selector has no meaningful candidate, so it never flags misalignment.
    assign misaligned = cand[0] & ~illegal;

endmodule

// File: rtl/pc_next_reg.sv
// Architectural PC register with RUN/HALT/ERR sequencing, stall handling,
// a one-cycle redirect flag and a saturating committed-update counter.
module pc_next_reg
    import pc_next_reg_pkg::*;
#(
    parameter int              WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       pc_src,
    input  logic             valid,
    input  logic             stall,
    input  logic             halt_req,
    input  logic [WIDTH-1:0] br_off,
    input  logic [WIDTH-1:0] jmp_off,
    input  logic [WIDTH-1:0] reg_tgt,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus2,
    output logic             redirect,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] upd_cnt
);

    pc_state_t        state, state_d;
    logic [WIDTH-1:0] cand, pc_d;
    logic             illegal, misaligned, nonseq;
    logic             redirect_d, commit;

    pc_target_mux #(.WIDTH(WIDTH)) u_mux (
        .pc         (pc),
        .pc_src     (pc_src),
        .br_off     (br_off),
        .jmp_off    (jmp_off),
        .reg_tgt    (reg_tgt),
        .pc_plus2   (pc_plus2),
        .cand       (cand),
        .illegal    (illegal),
        .misaligned (misaligned),
        .nonseq     (nonseq)
    );

    // Stall/invalid outrank halt, which outranks illegal selector and misalignment.
    always_comb begin
        state_d    = state;
        pc_d       = pc;
        redirect_d = 1'b0;
        commit     = 1'b0;
        case (state)
            ST_RUN: begin
                if (stall || !valid) begin
                    state_d = ST_RUN;
                end else if (halt_req) begin
                    state_d = ST_HALT;
                end else if (illegal || misaligned) begin
                    state_d = ST_ERR;
                end else begin
                    pc_d       = cand;
                    redirect_d = nonseq;
                    commit     = 1'b1;
                end
            end
            default: state_d = state;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RUN;
            pc       <= RESET_PC;
            redirect <= 1'b0;
            upd_cnt  <= '0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            redirect <= redirect_d;
            if (commit && (upd_cnt != '1)) begin
                upd_cnt <= upd_cnt + 1'b1;
            end
        end
    end

    assign halted = (state == ST_HALT);
    assign err    = (state == ST_ERR);

endmodule

// File: tb/tb_pc_next_reg.sv
// Self-checking bench: directed scenarios then randomized traffic, compared
// every cycle against a behavioural next-PC model.
module tb_pc_next_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  pc_src = 3'b000;
    logic        valid = 1'b0;
    logic        stall = 1'b0;
    logic        halt_req = 1'b0;
    logic [15:0] br_off = '0, jmp_off = '0, reg_tgt = '0;

    logic [15:0] pc, pc_plus2, pc4, pc_plus2_4;
    logic        redirect, halted, err, redirect4, halted4, err4;
    logic [15:0] upd_cnt;
    logic [3:0]  upd_cnt4;

    int errors = 0;
    int checks = 0;

    // Model state: mode 0=run, 1=halt, 2=err
    int      m_mode;
    int      m_pc;
    bit      m_redir;
    int      m_cnt;
    int      m_cnt4;

    pc_next_reg #(.WIDTH(16), .RESET_PC(16'h0000), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .pc_src(pc_src), .valid(valid), .stall(stall),
        .halt_req(halt_req), .br_off(br_off), .jmp_off(jmp_off), .reg_tgt(reg_tgt),
        .pc(pc), .pc_plus2(pc_plus2), .redirect(redirect), .halted(halted),
        .err(err), .upd_cnt(upd_cnt)
    );

    pc_next_reg #(.WIDTH(16), .RESET_PC(16'h0000), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .pc_src(pc_src), .valid(valid), .stall(stall),
        .halt_req(halt_req), .br_off(br_off), .jmp_off(jmp_off), .reg_tgt(reg_tgt),
        .pc(pc4), .pc_plus2(pc_plus2_4), .redirect(redirect4), .halted(halted4),
        .err(err4), .upd_cnt(upd_cnt4)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".pc"},       32'(pc),       32'(m_pc));
        checkOutput({tag, ".pc_plus2"}, 32'(pc_plus2), 32'((m_pc + 2) % 65536));
        checkOutput({tag, ".redirect"}, 32'(redirect), 32'(m_redir));
        checkOutput({tag, ".halted"},   32'(halted),   32'(m_mode == 1));
        checkOutput({tag, ".err"},      32'(err),      32'(m_mode == 2));
        checkOutput({tag, ".upd_cnt"},  32'(upd_cnt),  32'(m_cnt));
        checkOutput({tag, ".upd_cnt4"}, 32'(upd_cnt4), 32'(m_cnt4));
        checkOutput({tag, ".pc4"},      32'(pc4),      32'(m_pc));
    endtask

    function automatic void modelReset();
        m_mode  = 0;
        m_pc    = 0;
        m_redir = 0;
        m_cnt   = 0;
        m_cnt4  = 0;
    endfunction

    function automatic void modelStep(input int src, input bit v, input bit st, input bit hr,
                                      input int br, input int jmp, input int rt);
        int target;
        m_redir = 0;
        if (m_mode != 0) return;
        if (st || !v) return;
        if (hr) begin
            m_mode = 1;
            return;
        end
        case (src)
            0: target = m_pc;
            1: target = m_pc + 2;
            2: target = rt;
            3: target = m_pc + 2 + br;
            4: target = m_pc + 2 + jmp;
            default: begin
                m_mode = 2;
                return;
            end
        endcase
        target = target % 65536;
        if (target % 2 == 1) begin
            m_mode = 2;
            return;
        end
        m_pc    = target;
        m_redir = (src >= 2 && src <= 4);
        m_cnt   = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        m_cnt4  = (m_cnt4 < 15) ? m_cnt4 + 1 : 15;
    endfunction

    // Drive one cycle of inputs, advance the model on the edge, check 1 time unit later.
    task automatic applyStimulus(input logic [2:0] src, input bit v, input bit st, input bit hr,
                                 input logic [15:0] br, input logic [15:0] jmp,
                                 input logic [15:0] rt, input string tag);
        pc_src = src; valid = v; stall = st; halt_req = hr;
        br_off = br; jmp_off = jmp; reg_tgt = rt;
        @(posedge clk);
        modelStep(int'(src), v, st, hr, int'(br), int'(jmp), int'(rt));
        #1;
        checkAll(tag);
    endtask

    // Reset is raised between edges so the async path is observed without a clock.
    task automatic doReset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkAll(tag);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1;
        doReset("rst0");

        for (int i = 0; i < 4; i++) applyStimulus(3'b001, 1, 0, 0, 0, 0, 0, "seq");

        applyStimulus(3'b010, 1, 0, 0, 0, 0, 16'h0010, "to10");
        applyStimulus(3'b011, 1, 0, 0, 16'hFFF0, 0, 0, "br");
        applyStimulus(3'b100, 1, 0, 0, 0, 16'h0100, 0, "jdisp");
        applyStimulus(3'b010, 1, 0, 0, 0, 0, 16'h2000, "jreg");
        applyStimulus(3'b001, 1, 0, 0, 0, 0, 0, "seq_after");

        for (int i = 0; i < 3; i++) applyStimulus(3'b011, 1, 1, 0, 16'h0040, 0, 0, "stall");
        applyStimulus(3'b000, 1, 0, 0, 0, 0, 0, "hold");
        applyStimulus(3'b001, 0, 0, 0, 0, 0, 0, "invalid");

        applyStimulus(3'b010, 1, 0, 0, 0, 0, 16'h0040, "to40");
        applyStimulus(3'b001, 1, 1, 1, 0, 0, 0, "halt_stalled");
        applyStimulus(3'b001, 1, 0, 1, 0, 0, 0, "halt");
        for (int i = 0; i < 3; i++) applyStimulus(3'b001, 1, 0, 0, 0, 0, 0, "halt_frozen");
        doReset("rst_halt");

        applyStimulus(3'b110, 1, 0, 0, 0, 0, 0, "illegal");
        applyStimulus(3'b001, 1, 0, 0, 0, 0, 0, "err_frozen");
        doReset("rst_err");
        applyStimulus(3'b010, 1, 0, 0, 0, 0, 16'h0033, "misalign");
        doReset("rst_mis");
        applyStimulus(3'b111, 1, 0, 1, 0, 0, 0, "halt_over_illegal");
        doReset("rst_hi");

        applyStimulus(3'b010, 1, 0, 0, 0, 0, 16'hFFFE, "toFFFE");
        applyStimulus(3'b001, 1, 0, 0, 0, 0, 0, "wrap");
        applyStimulus(3'b010, 1, 0, 0, 0, 0, 16'hFFFC, "toFFFC");
        applyStimulus(3'b011, 1, 0, 0, 16'h0004, 0, 0, "br_wrap");
        applyStimulus(3'b011, 1, 1, 0, 0, 0, 0, "stall_mid");
        doReset("rst_stall");

        for (int i = 0; i < 20; i++) applyStimulus(3'b001, 1, 0, 0, 0, 0, 0, "sat");

        for (int i = 0; i < 400; i++) begin
            logic [2:0]  src;
            logic [15:0] br, jmp, rt;
            int          r;
            if ((m_mode != 0 && $urandom_range(0, 3) == 0) || $urandom_range(0, 60) == 0) begin
                doReset("rnd_rst");
            end
            r = $urandom_range(0, 19);
            if (r < 7)       src = 3'b001;
            else if (r < 10) src = 3'b011;
            else if (r < 12) src = 3'b100;
            else if (r < 14) src = 3'b010;
            else if (r < 17) src = 3'b000;
            else             src = 3'($urandom_range(5, 7));
            br  = 16'($urandom) & 16'hFFFE;
            jmp = 16'($urandom) & 16'hFFFE;
            rt  = 16'($urandom) & 16'hFFFE;
            if ($urandom_range(0, 15) == 0) rt[0] = 1'b1;
            if ($urandom_range(0, 15) == 0) br[0] = 1'b1;
            applyStimulus(src, ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 40) == 0), br, jmp, rt, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
